// File: rtl/can_rx_frame_fifo.sv
// CAN receive-frame FIFO with a 4-register CPU window.
// Optional macro CAN_RXF_OVERWRITE_EN: a push into a full queue overwrites the oldest frame.
module can_rx_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [28:0] in_id,
  input  logic        in_ext,
  input  logic        in_rtr,
  input  logic [3:0]  in_dlc,
  input  logic [63:0] in_data,
  input  logic        cs,
  input  logic [1:0]  rs,
  input  logic [3:0]  bytesel,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        irq
);

  typedef struct packed {
    logic        ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [28:0] id;
    logic [63:0] data;
  } entry_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0] count;
  logic [7:0]  lost;
  logic        ovf;
  logic        irqen;

  logic wr, rd, st_wr;
  logic pop_req, flush, clr;
  logic full, empty;
  logic pop, take, drop_ev, over, wen;
  logic [2:0]  cnt3;
  logic [31:0] status;
  logic        unused;

  assign wr      = cs & (bytesel == 4'hF);
  assign rd      = cs & (bytesel == 4'h0);
  assign st_wr   = wr & (rs == 2'd1);
  assign pop_req = st_wr & d[0];
  assign flush   = st_wr & d[1];
  assign clr     = st_wr & d[2];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop on a full queue frees the slot, so the push is accepted
  assign pop     = pop_req & ~empty;
  assign take    = push & (~full | pop) & ~flush;
  assign drop_ev = push & full & ~pop & ~flush;

`ifdef CAN_RXF_OVERWRITE_EN
  assign over = drop_ev;
`else
  assign over = 1'b0;
`endif

  assign wen = take | over;

  assign head   = mem[rptr];
  assign cnt3   = 3'(count);
  assign status = {irqen, 15'h0, lost, ovf, 2'b00, full, empty, cnt3};

  // Bits with no function in this block
  assign unused = ^{d[30:3], head.dlc};

  // Frame storage; contents deliberately left unreset
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[wptr] <= {in_ext, in_rtr, in_dlc, in_id, in_data};
    end
  end

  // Pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wen) wptr <= wptr + AW'(1);
      if (pop | over) rptr <= rptr + AW'(1);
      if (take & ~pop) count <= count + (AW+1)'(1);
      else if (pop & ~take) count <= count - (AW+1)'(1);
    end
  end

  // Overflow bookkeeping; software clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lost <= '0;
      ovf  <= 1'b0;
    end else if (clr) begin
      lost <= '0;
      ovf  <= 1'b0;
    end else if (drop_ev) begin
      ovf <= 1'b1;
      if (lost != 8'hFF) lost <= lost + 8'd1;
    end
  end

  // Interrupt enable and registered interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqen <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (st_wr) irqen <= d[31];
      irq <= irqen & ~empty;
    end
  end

  // Read window onto the head frame and status
  always_comb begin
    q = '0;
    if (rd) begin
      unique case (rs)
        2'd0: if (!empty) q = {head.ext, head.rtr, 1'b0, head.id};
        2'd1: q = status;
        2'd2: if (!empty) q = head.data[31:0];
        2'd3: if (!empty) q = head.data[63:32];
        default: q = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Scoreboard bench for can_rx_frame_fifo.
// Reads and irq samples are queued by stimulus and compared by a monitor.
module tb_can_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [28:0] in_id;
  logic        in_ext;
  logic        in_rtr;
  logic [3:0]  in_dlc;
  logic [63:0] in_data;
  logic        cs;
  logic [1:0]  rs;
  logic [3:0]  bytesel;
  logic [31:0] d;
  logic [31:0] q;
  logic        irq;
  logic        irq_chk;

  int errors = 0;
  int checks = 0;

`ifdef CAN_RXF_OVERWRITE_EN
  localparam int OVB = 2;
`else
  localparam int OVB = 1;
`endif

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t qexp[$];
  exp_t iexp[$];

  always #5 clk = ~clk;

  can_rx_frame_fifo dut (
    .clk(clk), .reset(reset), .push(push),
    .in_id(in_id), .in_ext(in_ext), .in_rtr(in_rtr),
    .in_dlc(in_dlc), .in_data(in_data),
    .cs(cs), .rs(rs), .bytesel(bytesel), .d(d),
    .q(q), .irq(irq)
  );

  // Monitor: compare whatever the DUT presents against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (cs && bytesel == 4'h0) begin
      checks++;
      if (qexp.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got %h, nothing expected", q);
      end else begin
        e = qexp.pop_front();
        if (q !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, q, e.val);
        end
      end
    end
    if (irq_chk) begin
      checks++;
      if (iexp.size() == 0) begin
        errors++;
        $display("FAIL irq_unexpected: got %b", irq);
      end else begin
        e = iexp.pop_front();
        if (irq !== e.val[0]) begin
          errors++;
          $display("FAIL %s: got %b expected %b", e.name, irq, e.val[0]);
        end
      end
      checks++;
      if (q !== 32'h0) begin
        errors++;
        $display("FAIL q_idle: got %h expected 00000000", q);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] r, input logic [31:0] v,
                        input string n);
    qexp.push_back('{n, v});
    cs = 1'b1; rs = r; bytesel = 4'h0;
    tick();
    cs = 1'b0;
  endtask

  task automatic wr_st(input logic [31:0] v);
    cs = 1'b1; rs = 2'd1; bytesel = 4'hF; d = v;
    tick();
    cs = 1'b0; bytesel = 4'h0; d = '0;
  endtask

  task automatic set_frame(input logic [28:0] id, input logic ext,
                           input logic rtr, input logic [63:0] dat);
    in_id = id; in_ext = ext; in_rtr = rtr;
    in_dlc = 4'd8; in_data = dat; push = 1'b1;
  endtask

  task automatic push_f(input logic [28:0] id, input logic [63:0] dat);
    set_frame(id, 1'b0, 1'b0, dat);
    tick();
    push = 1'b0;
  endtask

  task automatic push_st(input logic [28:0] id, input logic [31:0] v);
    set_frame(id, 1'b0, 1'b0, 64'h0);
    cs = 1'b1; rs = 2'd1; bytesel = 4'hF; d = v;
    tick();
    push = 1'b0; cs = 1'b0; bytesel = 4'h0; d = '0;
  endtask

  task automatic chk_irq(input logic v, input string n);
    iexp.push_back('{n, {31'h0, v}});
    irq_chk = 1'b1;
    tick();
    irq_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; push = 1'b0; in_id = '0; in_ext = 1'b0; in_rtr = 1'b0;
    in_dlc = '0; in_data = '0; cs = 1'b0; rs = '0; bytesel = '0;
    d = '0; irq_chk = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    rd_reg(2'd1, 32'h0000_0008, "reset_status");
    chk_irq(1'b0, "reset_irq");
    rd_reg(2'd0, 32'h0, "reset_id");
    rd_reg(2'd2, 32'h0, "reset_data0");

    // Single frame visibility
    push_f(29'h123, 64'h0706050403020100);
    rd_reg(2'd1, 32'h0000_0001, "push1_status");
    rd_reg(2'd0, 32'h0000_0123, "push1_id");
    rd_reg(2'd2, 32'h0302_0100, "push1_data0");
    rd_reg(2'd3, 32'h0706_0504, "push1_data1");
    wr_st(32'h1);
    rd_reg(2'd1, 32'h0000_0008, "pop1_status");

    // Interrupt timing, extended/remote flags
    wr_st(32'h8000_0000);
    rd_reg(2'd1, 32'h8000_0008, "irqen_status");
    set_frame(29'h1ABCDEF, 1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D);
    tick();
    push = 1'b0;
    chk_irq(1'b0, "irq_lag");
    chk_irq(1'b1, "irq_set");
    rd_reg(2'd0, 32'hC1AB_CDEF, "ext_id");
    rd_reg(2'd2, 32'hCAFE_F00D, "ext_data0");
    rd_reg(2'd3, 32'hDEAD_BEEF, "ext_data1");
    wr_st(32'h8000_0001);
    chk_irq(1'b1, "irq_pop_lag");
    chk_irq(1'b0, "irq_clear");
    rd_reg(2'd1, 32'h8000_0008, "irq_pop_status");
    wr_st(32'h0);
    rd_reg(2'd1, 32'h0000_0008, "irqen_off_status");

    // Overflow by one
    for (int i = 1; i <= 5; i++) push_f(29'(i), 64'h0);
    rd_reg(2'd1, 32'h0000_0194, "ovf_status");
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'd0, 32'(OVB + i), "ovf_order_id");
      wr_st(32'h1);
    end
    rd_reg(2'd1, 32'h0000_0188, "ovf_drained");

    // Lost counter saturation and clear
    for (int i = 0; i < 4; i++) push_f(29'(16 + i), 64'h0);
    for (int i = 0; i < 300; i++) push_f(29'(256 + i), 64'h0);
    rd_reg(2'd1, 32'h0000_FF94, "lost_sat");
    wr_st(32'h4);
    rd_reg(2'd1, 32'h0000_0014, "lost_clear");
    wr_st(32'h2);
    rd_reg(2'd1, 32'h0000_0008, "flush_status");

    // Push and pop together on full, then on empty
    for (int i = 0; i < 4; i++) push_f(29'(33 + i), 64'h0);
    push_st(29'h9, 32'h1);
    rd_reg(2'd1, 32'h0000_0014, "pp_full_status");
    rd_reg(2'd0, 32'h0000_0022, "pp_full_head");
    wr_st(32'h1);
    rd_reg(2'd0, 32'h0000_0023, "pp_head2");
    wr_st(32'h1);
    rd_reg(2'd0, 32'h0000_0024, "pp_head3");
    wr_st(32'h1);
    rd_reg(2'd0, 32'h0000_0009, "pp_id9");
    rd_reg(2'd1, 32'h0000_0001, "pp_count1");
    wr_st(32'h1);
    wr_st(32'h1);
    rd_reg(2'd1, 32'h0000_0008, "pop_empty");
    push_st(29'h55, 32'h1);
    rd_reg(2'd1, 32'h0000_0001, "pp_empty_status");
    rd_reg(2'd0, 32'h0000_0055, "pp_empty_id");

    // Flush beats push; lost-clear beats overflow increment
    push_f(29'h31, 64'h0);
    push_st(29'h32, 32'h2);
    rd_reg(2'd1, 32'h0000_0008, "push_flush");
    for (int i = 0; i < 5; i++) push_f(29'(65 + i), 64'h0);
    rd_reg(2'd1, 32'h0000_0194, "pre_clr_status");
    push_st(29'h46, 32'h4);
    rd_reg(2'd1, 32'h0000_0014, "push_clr");
    wr_st(32'h2);

    // Reset mid-burst
    wr_st(32'h8000_0000);
    for (int i = 0; i < 3; i++) push_f(29'(80 + i), 64'h0);
    tick();
    chk_irq(1'b1, "pre_reset_irq");
    rd_reg(2'd1, 32'h8000_0003, "pre_reset_status");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    rd_reg(2'd1, 32'h0000_0008, "post_reset_status");
    chk_irq(1'b0, "post_reset_irq");

    tick();
    checks++;
    if (qexp.size() != 0 || iexp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0",
               qexp.size() + iexp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
